// File: rtl/pfmon_pkg.sv
// pfmon_pkg: shared types and constants for the prefetch-interface monitor.
// Holds the monitor state enum and the bit positions inside o_err_code.
package pfmon_pkg;

  // Monitor view of the fetch stream: waiting for a PC, running, or parked
  // behind a bus error until the CPU redirects.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ILL  = 2'd2
  } pf_state_e;

  localparam int ERR_BITS     = 5;
  localparam int ERR_HOLD     = 0;
  localparam int ERR_ADDR     = 1;
  localparam int ERR_EARLY    = 2;
  localparam int ERR_ILLDROP  = 3;
  localparam int ERR_CONTRACT = 4;

endpackage

// File: rtl/pfmon_satcnt.sv
// pfmon_satcnt: saturating up-counter, sticks at all-ones instead of wrapping.
module pfmon_satcnt #(
  parameter int CW = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          inc,
  output logic [CW-1:0] o_count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Increment unless already at the ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CW{1'b1}})) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pf_monitor.sv
// pf_monitor: passive protocol checker sitting between a prefetch unit and
// the CPU. Tracks the expected fetch address, watches stalled beats for
// stability, and latches sticky error bits plus beat/stall statistics.
// Optional macro PFMON_CONTRACT_EN adds a fetch-contract check against an
// externally supplied (fc_pc, fc_insn, fc_illegal) reference.
module pf_monitor
  import pfmon_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 30,
  parameter int NLANES        = 1,
  parameter int CW            = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     cpu_new_pc,
  input  logic                     cpu_clear_cache,
  input  logic [ADDRESS_WIDTH+1:0] cpu_pc,
  input  logic                     pf_valid,
  input  logic                     cpu_ready,
  input  logic [ADDRESS_WIDTH+1:0] pf_pc,
  input  logic [32*NLANES-1:0]     pf_insn,
  input  logic                     pf_illegal,
`ifdef PFMON_CONTRACT_EN
  input  logic [ADDRESS_WIDTH+1:0] fc_pc,
  input  logic [31:0]              fc_insn,
  input  logic                     fc_illegal,
`endif
  input  logic                     i_clr_err,
  output logic                     o_err,
  output logic [4:0]               o_err_code,
  output logic [CW-1:0]            o_beats,
  output logic [CW-1:0]            o_stalls
);

  localparam int AW = ADDRESS_WIDTH;

  pf_state_e              state_q, state_d;
  logic [AW+1:0]          exp_q, exp_d;
  logic                   snap_valid_q, snap_valid_d;
  logic [AW+1:0]          snap_pc_q, snap_pc_d;
  logic [32*NLANES-1:0]   snap_insn_q, snap_insn_d;
  logic                   snap_ill_q, snap_ill_d;
  logic                   prev_new_pc_q, prev_new_pc_d;
  logic                   prev_clear_q, prev_clear_d;
  logic [ERR_BITS-1:0]    err_q, err_d;
  logic [ERR_BITS-1:0]    viol;

  logic accept;
  logic stall;
  logic contract_viol;

  assign accept = pf_valid && cpu_ready;
  assign stall  = pf_valid && !cpu_ready;

`ifdef PFMON_CONTRACT_EN
  // Word distance from lane 0 of the beat to the reference PC; the reference
  // falls inside the beat when that distance is below NLANES (wraps modulo 2^AW).
  logic [AW-1:0]     fc_off;
  logic [NLANES-1:0] lane_bad;
  logic              unused_fc_byte;

  assign fc_off         = fc_pc[AW+1:2] - pf_pc[AW+1:2];
  assign unused_fc_byte = ^fc_pc[1:0];

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    assign lane_bad[gi] = (fc_off == AW'(gi)) && !pf_illegal &&
                          (fc_illegal || (pf_insn[32*gi +: 32] != fc_insn));
  end

  assign contract_viol = pf_valid && (|lane_bad);
`else
  assign contract_viol = 1'b0;
`endif

  // Next state: a new PC always restarts the stream, even alongside a clear.
  always_comb begin
    state_d = state_q;
    if (cpu_new_pc) begin
      state_d = ST_RUN;
    end else if (cpu_clear_cache) begin
      state_d = ST_IDLE;
    end else if ((state_q == ST_RUN) && pf_valid && pf_illegal) begin
      state_d = ST_ILL;
    end
  end

  // Expected address: reload on redirect, else step one beat on accept.
  always_comb begin
    exp_d = exp_q;
    if (cpu_new_pc) begin
      exp_d = cpu_pc;
    end else if (accept) begin
      exp_d = {exp_q[AW+1:2] + AW'(NLANES), 2'b00};
    end
  end

  // Stall snapshot and one-cycle history of the CPU control strobes.
  always_comb begin
    snap_valid_d  = stall;
    snap_pc_d     = snap_pc_q;
    snap_insn_d   = snap_insn_q;
    snap_ill_d    = snap_ill_q;
    prev_new_pc_d = cpu_new_pc;
    prev_clear_d  = cpu_clear_cache;
    if (stall) begin
      snap_pc_d   = pf_pc;
      snap_insn_d = pf_insn;
      snap_ill_d  = pf_illegal;
    end
  end

  // Protocol checks on the current inputs; sticky bits with set-over-clear.
  always_comb begin
    viol = '0;
    viol[ERR_HOLD]     = snap_valid_q && !prev_new_pc_q && !cpu_new_pc &&
                         (!pf_valid || (pf_pc != snap_pc_q) ||
                          (pf_insn != snap_insn_q) || (pf_illegal != snap_ill_q));
    viol[ERR_ADDR]     = (state_q == ST_RUN) && pf_valid && !pf_illegal &&
                         (pf_pc != exp_q);
    viol[ERR_EARLY]    = pf_valid && ((state_q == ST_IDLE) || prev_clear_q);
    viol[ERR_ILLDROP]  = (state_q == ST_ILL) && !cpu_new_pc && !pf_illegal;
    viol[ERR_CONTRACT] = contract_viol;
    err_d = (i_clr_err ? '0 : err_q) | viol;
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      exp_q         <= '0;
      snap_valid_q  <= 1'b0;
      snap_pc_q     <= '0;
      snap_insn_q   <= '0;
      snap_ill_q    <= 1'b0;
      prev_new_pc_q <= 1'b0;
      prev_clear_q  <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      exp_q         <= exp_d;
      snap_valid_q  <= snap_valid_d;
      snap_pc_q     <= snap_pc_d;
      snap_insn_q   <= snap_insn_d;
      snap_ill_q    <= snap_ill_d;
      prev_new_pc_q <= prev_new_pc_d;
      prev_clear_q  <= prev_clear_d;
      err_q         <= err_d;
    end
  end

  pfmon_satcnt #(.CW(CW)) u_beats (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .inc       (accept),
    .o_count   (o_beats)
  );

  pfmon_satcnt #(.CW(CW)) u_stalls (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .inc       (stall),
    .o_count   (o_stalls)
  );

  assign o_err      = |err_q;
  assign o_err_code = err_q;

endmodule

// File: tb/tb_pf_monitor.sv
// tb_pf_monitor: directed scenarios on a default-parameter monitor (A) and
// directed plus randomized model-checked traffic on a narrow, two-lane,
// 4-bit-counter monitor (B). Honours PFMON_CONTRACT_EN when defined.
module tb_pf_monitor;

  localparam int AAW = 30;
  localparam int ANL = 1;
  localparam int ACW = 16;
  localparam int BAW = 10;
  localparam int BNL = 2;
  localparam int BCW = 4;

  logic i_clk     = 1'b0;
  logic i_reset_n = 1'b1;

  logic             a_new_pc, a_clear, a_valid, a_ready, a_ill, a_clr;
  logic [AAW+1:0]   a_cpu_pc, a_pf_pc;
  logic [32*ANL-1:0] a_insn;
  logic             a_err;
  logic [4:0]       a_code;
  logic [ACW-1:0]   a_beats, a_stalls;

  logic             b_new_pc, b_clear, b_valid, b_ready, b_ill, b_clr;
  logic [BAW+1:0]   b_cpu_pc, b_pf_pc;
  logic [32*BNL-1:0] b_insn;
  logic             b_err;
  logic [4:0]       b_code;
  logic [BCW-1:0]   b_beats, b_stalls;

`ifdef PFMON_CONTRACT_EN
  logic [AAW+1:0]   a_fc_pc;
  logic [31:0]      a_fc_insn;
  logic             a_fc_ill;
  logic [BAW+1:0]   b_fc_pc;
  logic [31:0]      b_fc_insn;
  logic             b_fc_ill;
`endif

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pf_monitor #(.ADDRESS_WIDTH(AAW), .NLANES(ANL), .CW(ACW)) u_dut_a (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .cpu_new_pc      (a_new_pc),
    .cpu_clear_cache (a_clear),
    .cpu_pc          (a_cpu_pc),
    .pf_valid        (a_valid),
    .cpu_ready       (a_ready),
    .pf_pc           (a_pf_pc),
    .pf_insn         (a_insn),
    .pf_illegal      (a_ill),
`ifdef PFMON_CONTRACT_EN
    .fc_pc           (a_fc_pc),
    .fc_insn         (a_fc_insn),
    .fc_illegal      (a_fc_ill),
`endif
    .i_clr_err       (a_clr),
    .o_err           (a_err),
    .o_err_code      (a_code),
    .o_beats         (a_beats),
    .o_stalls        (a_stalls)
  );

  pf_monitor #(.ADDRESS_WIDTH(BAW), .NLANES(BNL), .CW(BCW)) u_dut_b (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .cpu_new_pc      (b_new_pc),
    .cpu_clear_cache (b_clear),
    .cpu_pc          (b_cpu_pc),
    .pf_valid        (b_valid),
    .cpu_ready       (b_ready),
    .pf_pc           (b_pf_pc),
    .pf_insn         (b_insn),
    .pf_illegal      (b_ill),
`ifdef PFMON_CONTRACT_EN
    .fc_pc           (b_fc_pc),
    .fc_insn         (b_fc_insn),
    .fc_illegal      (b_fc_ill),
`endif
    .i_clr_err       (b_clr),
    .o_err           (b_err),
    .o_err_code      (b_code),
    .o_beats         (b_beats),
    .o_stalls        (b_stalls)
  );

  task automatic idle_inputs();
    a_new_pc = 0; a_clear = 0; a_valid = 0; a_ready = 0; a_ill = 0; a_clr = 0;
    a_cpu_pc = '0; a_pf_pc = '0; a_insn = '0;
    b_new_pc = 0; b_clear = 0; b_valid = 0; b_ready = 0; b_ill = 0; b_clr = 0;
    b_cpu_pc = '0; b_pf_pc = '0; b_insn = '0;
`ifdef PFMON_CONTRACT_EN
    a_fc_pc = '0; a_fc_insn = '0; a_fc_ill = 0;
    b_fc_pc = '0; b_fc_insn = '0; b_fc_ill = 0;
`endif
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset_n = 1'b0;
    tick();
    tick();
    i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 i_reset_n = 1'b0;
    #1;
    checks++; if (a_code !== 5'b0) begin errors++; $display("FAIL reset_code got=%b exp=%b", a_code, 5'b0); end
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", a_err); end
    checks++; if (a_beats !== '0 || a_stalls !== '0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", a_beats, a_stalls); end
    checks++; if (b_code !== 5'b0 || b_beats !== '0) begin errors++; $display("FAIL reset_b got=%b/%0d exp=0/0", b_code, b_beats); end
    tick();
    i_reset_n = 1'b1;
    a_valid = 1; a_ready = 0;
    tick();
    $display("reset release with pf_valid high: code=%b stalls=%0d", a_code, a_stalls);
    checks++; if (a_code !== 5'b00100) begin errors++; $display("FAIL release_early got=%b exp=%b", a_code, 5'b00100); end
    checks++; if (a_stalls !== 16'd1) begin errors++; $display("FAIL release_stalls got=%0d exp=1", a_stalls); end
    #2 i_reset_n = 1'b0;
    #1;
    checks++; if (a_code !== 5'b0 || a_err !== 1'b0) begin errors++; $display("FAIL midstall_reset_code got=%b/%b exp=0/0", a_code, a_err); end
    checks++; if (a_stalls !== '0) begin errors++; $display("FAIL midstall_reset_stalls got=%0d exp=0", a_stalls); end
  endtask

  task automatic test_basic();
    do_reset();
    a_new_pc = 1; a_cpu_pc = 32'h100;
    tick();
    a_new_pc = 0; a_valid = 1; a_ready = 1; a_pf_pc = 32'h100; a_insn = $urandom;
    tick();
    a_pf_pc = 32'h104; a_insn = $urandom;
    tick();
    a_valid = 0;
    tick();
    $display("basic: two beats code=%b beats=%0d", a_code, a_beats);
    checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL basic_err got=%b exp=0", a_err); end
    checks++; if (a_beats !== 16'd2) begin errors++; $display("FAIL basic_beats got=%0d exp=2", a_beats); end
  endtask

  task automatic test_wrap();
    logic [11:0] pcs [3] = '{12'hFF8, 12'h000, 12'h008};
    do_reset();
    b_new_pc = 1; b_cpu_pc = 12'hFF8;
    tick();
    b_new_pc = 0; b_valid = 1; b_ready = 1;
    for (int i = 0; i < 3; i++) begin
      b_pf_pc = pcs[i]; b_insn = {$urandom, 32'h0};
      tick();
      $display("wrap: beat pc=%h code=%b", pcs[i], b_code);
      checks++; if (b_code !== 5'b0) begin errors++; $display("FAIL wrap_beat%0d got=%b exp=%b", i, b_code, 5'b0); end
    end
    checks++; if (b_beats !== 4'd3) begin errors++; $display("FAIL wrap_beats got=%0d exp=3", b_beats); end
    b_pf_pc = 12'h008;
    tick();
    $display("wrap: repeated beat pc=008 code=%b", b_code);
    checks++; if (b_code !== 5'b00010) begin errors++; $display("FAIL wrap_addr got=%b exp=%b", b_code, 5'b00010); end
  endtask

  task automatic test_hold();
    do_reset();
    a_new_pc = 1; a_cpu_pc = 32'h100;
    tick();
    a_new_pc = 0; a_valid = 1; a_ready = 0; a_pf_pc = 32'h100; a_insn = 32'hDEADBEEF;
    tick();
    tick();
    checks++; if (a_code !== 5'b0) begin errors++; $display("FAIL hold_stable got=%b exp=%b", a_code, 5'b0); end
    a_insn = 32'h0;
    tick();
    $display("hold: insn changed mid-stall code=%b stalls=%0d", a_code, a_stalls);
    checks++; if (a_code !== 5'b00001) begin errors++; $display("FAIL hold_code got=%b exp=%b", a_code, 5'b00001); end
    checks++; if (a_stalls !== 16'd3) begin errors++; $display("FAIL hold_stalls got=%0d exp=3", a_stalls); end
  endtask

  task automatic test_early();
    do_reset();
    a_new_pc = 1; a_cpu_pc = 32'h200;
    tick();
    a_new_pc = 0; a_clear = 1;
    tick();
    a_clear = 0; a_valid = 1; a_ready = 1; a_pf_pc = 32'h200;
    tick();
    checks++; if (a_code !== 5'b00100) begin errors++; $display("FAIL early_after_clear got=%b exp=%b", a_code, 5'b00100); end
    a_clr = 1;
    tick();
    checks++; if (a_code !== 5'b00100) begin errors++; $display("FAIL early_set_wins got=%b exp=%b", a_code, 5'b00100); end
    a_valid = 0; a_new_pc = 1; a_clear = 1; a_cpu_pc = 32'h300;
    tick();
    checks++; if (a_code !== 5'b0) begin errors++; $display("FAIL early_cleared got=%b exp=%b", a_code, 5'b0); end
    a_clr = 0; a_new_pc = 0; a_clear = 0; a_valid = 1; a_pf_pc = 32'h300;
    tick();
    checks++; if (a_code !== 5'b00100) begin errors++; $display("FAIL early_newpc_clear got=%b exp=%b", a_code, 5'b00100); end
    a_clr = 1; a_pf_pc = 32'h304;
    tick();
    $display("early: run resumed at 304 code=%b", a_code);
    checks++; if (a_code !== 5'b0) begin errors++; $display("FAIL early_resume got=%b exp=%b", a_code, 5'b0); end
  endtask

  task automatic test_illdrop();
    do_reset();
    a_new_pc = 1; a_cpu_pc = 32'h100;
    tick();
    a_new_pc = 0; a_valid = 1; a_ready = 1; a_ill = 1; a_pf_pc = 32'h100;
    tick();
    checks++; if (a_code !== 5'b0) begin errors++; $display("FAIL ill_beat got=%b exp=%b", a_code, 5'b0); end
    a_valid = 0; a_ill = 0;
    tick();
    $display("illdrop: illegal dropped code=%b", a_code);
    checks++; if (a_code !== 5'b01000) begin errors++; $display("FAIL ill_drop got=%b exp=%b", a_code, 5'b01000); end
    do_reset();
    a_new_pc = 1; a_cpu_pc = 32'h100;
    tick();
    a_new_pc = 0; a_valid = 1; a_ready = 1; a_ill = 1; a_pf_pc = 32'h100;
    tick();
    a_valid = 0;
    tick();
    checks++; if (a_code !== 5'b0) begin errors++; $display("FAIL ill_held got=%b exp=%b", a_code, 5'b0); end
    a_new_pc = 1; a_cpu_pc = 32'h400; a_ill = 0;
    tick();
    checks++; if (a_code !== 5'b0) begin errors++; $display("FAIL ill_redirect got=%b exp=%b", a_code, 5'b0); end
    a_new_pc = 0; a_valid = 1; a_pf_pc = 32'h400;
    tick();
    $display("illdrop: redirect to 400 code=%b", a_code);
    checks++; if (a_code !== 5'b0) begin errors++; $display("FAIL ill_rerun got=%b exp=%b", a_code, 5'b0); end
  endtask

  task automatic test_contract();
    logic [4:0] want;
`ifdef PFMON_CONTRACT_EN
    want = 5'b10000;
`else
    want = 5'b00000;
`endif
    do_reset();
`ifdef PFMON_CONTRACT_EN
    a_fc_pc = 32'h200; a_fc_insn = 32'h12345678; a_fc_ill = 0;
`endif
    a_new_pc = 1; a_cpu_pc = 32'h200;
    tick();
    a_new_pc = 0; a_valid = 1; a_ready = 1; a_pf_pc = 32'h200; a_insn = 32'h12345679;
    tick();
    $display("contract: beat 200 insn=12345679 code=%b", a_code);
    checks++; if (a_code !== want) begin errors++; $display("FAIL contract_bit got=%b exp=%b", a_code, want); end
    a_clr = 1; a_pf_pc = 32'h204; a_insn = 32'h12345679;
    tick();
    checks++; if (a_code !== 5'b0) begin errors++; $display("FAIL contract_outside got=%b exp=%b", a_code, 5'b0); end
  endtask

  task automatic test_saturate();
    do_reset();
    b_new_pc = 1; b_cpu_pc = 12'h000;
    tick();
    b_new_pc = 0; b_valid = 1; b_ready = 1;
    for (int i = 0; i < 20; i++) begin
      b_pf_pc = 12'(i * 8);
      tick();
    end
    $display("saturate: 20 beats beats=%0d code=%b", b_beats, b_code);
    checks++; if (b_beats !== 4'hF) begin errors++; $display("FAIL sat_beats got=%0d exp=15", b_beats); end
    b_ready = 0; b_pf_pc = 12'h0A0;
    for (int i = 0; i < 20; i++) tick();
    $display("saturate: 20 stalls stalls=%0d code=%b", b_stalls, b_code);
    checks++; if (b_stalls !== 4'hF || b_beats !== 4'hF) begin errors++; $display("FAIL sat_stalls got=%0d/%0d exp=15/15", b_stalls, b_beats); end
    checks++; if (b_code !== 5'b0) begin errors++; $display("FAIL sat_code got=%b exp=%b", b_code, 5'b0); end
  endtask

  task automatic test_random();
    int unsigned m_mode;     // 0: waiting for a PC, 1: running, 2: parked after bus error
    logic [11:0] m_exp;
    logic [4:0]  m_err, viol;
    int unsigned m_beats, m_stalls, off;
    logic        p_stall, p_newpc, p_clear, p_ill;
    logic [11:0] p_pc;
    logic [63:0] p_insn;
    logic [31:0] lane;
    do_reset();
    m_mode = 0; m_exp = '0; m_err = '0; m_beats = 0; m_stalls = 0;
    p_stall = 0; p_newpc = 0; p_clear = 0; p_ill = 0; p_pc = '0; p_insn = '0;
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) begin
        #2 i_reset_n = 1'b0;
        #1;
        checks++; if (b_code !== 5'b0 || b_beats !== '0 || b_stalls !== '0) begin errors++; $display("FAIL rand_reset got=%b/%0d/%0d exp=0/0/0", b_code, b_beats, b_stalls); end
        tick();
        i_reset_n = 1'b1;
        m_mode = 0; m_exp = '0; m_err = '0; m_beats = 0; m_stalls = 0;
        p_stall = 0; p_newpc = 0; p_clear = 0; p_ill = 0;
      end
      b_new_pc = ($urandom_range(0, 99) < 8);
      b_clear  = ($urandom_range(0, 99) < 4);
      b_cpu_pc = {10'($urandom), 2'b00};
      b_ready  = ($urandom_range(0, 99) < 70);
      b_clr    = ($urandom_range(0, 99) < 40);
      if (p_stall && ($urandom_range(0, 99) < 85)) begin
        b_valid = 1; b_pf_pc = p_pc; b_insn = p_insn; b_ill = p_ill;
      end else begin
        b_valid = ($urandom_range(0, 99) < 60);
        b_pf_pc = ($urandom_range(0, 99) < 85) ? m_exp : 12'($urandom);
        b_insn  = {$urandom, $urandom};
        b_ill   = ($urandom_range(0, 99) < 5);
      end
      viol = '0;
      viol[0] = p_stall && !p_newpc && !b_new_pc &&
                (!b_valid || b_pf_pc != p_pc || b_insn != p_insn || b_ill != p_ill);
      viol[1] = (m_mode == 1) && b_valid && !b_ill && (b_pf_pc != m_exp);
      viol[2] = b_valid && ((m_mode == 0) || p_clear);
      viol[3] = (m_mode == 2) && !b_new_pc && !b_ill;
`ifdef PFMON_CONTRACT_EN
      b_fc_pc   = ($urandom_range(0, 1) == 1) ? b_pf_pc + 12'(4 * $urandom_range(0, 3)) : 12'($urandom);
      b_fc_ill  = ($urandom_range(0, 9) == 0);
      b_fc_insn = ($urandom_range(0, 1) == 1) ? b_insn[31:0] : $urandom;
      off  = (int'(b_fc_pc[11:2]) + 1024 - int'(b_pf_pc[11:2])) % 1024;
      lane = (off == 0) ? b_insn[31:0] : b_insn[63:32];
      if (b_valid && off < BNL && !b_ill) viol[4] = b_fc_ill || (lane != b_fc_insn);
`else
      off = 0; lane = '0;
`endif
      m_err = (b_clr ? 5'b0 : m_err) | viol;
      if (b_valid && b_ready && m_beats < 15) m_beats++;
      if (b_valid && !b_ready && m_stalls < 15) m_stalls++;
      if (b_new_pc) m_mode = 1;
      else if (b_clear) m_mode = 0;
      else if (m_mode == 1 && b_valid && b_ill) m_mode = 2;
      if (b_new_pc) m_exp = b_cpu_pc;
      else if (b_valid && b_ready) m_exp = 12'(((int'(m_exp) / 4 + BNL) % 1024) * 4);
      p_stall = b_valid && !b_ready; p_pc = b_pf_pc; p_insn = b_insn; p_ill = b_ill;
      p_newpc = b_new_pc; p_clear = b_clear;
      if (b_valid && b_ready) $display("rand beat n=%0d pc=%h ill=%b expect_code=%b", n, b_pf_pc, b_ill, m_err);
      tick();
      checks++; if (b_code !== m_err) begin errors++; $display("FAIL rand_code n=%0d got=%b exp=%b", n, b_code, m_err); end
      checks++; if (b_beats !== 4'(m_beats) || b_stalls !== 4'(m_stalls)) begin errors++; $display("FAIL rand_counts n=%0d got=%0d/%0d exp=%0d/%0d", n, b_beats, b_stalls, m_beats, m_stalls); end
      checks++; if (b_err !== (|m_err)) begin errors++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, b_err, |m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_early();
    test_illdrop();
    test_contract();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pf_monitor.md
PF_MONITOR -- requirements
Module: pf_monitor

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 30: word-address width (AW); PCs are AW+2 bits.
REQ-002 Parameter NLANES, default 1: 32-bit instructions per fetch beat; legal values 1, 2, 4.
REQ-003 Parameter CW, default 16: statistics counter width.
REQ-004 Port i_clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port i_reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port cpu_new_pc, input, 1: CPU branch/restart request.
REQ-007 Port cpu_clear_cache, input, 1: CPU cache-clear request.
REQ-008 Port cpu_pc, input, AW+2: new PC, qualified by cpu_new_pc.
REQ-009 Port pf_valid, input, 1: prefetch beat valid.
REQ-010 Port cpu_ready, input, 1: CPU accepts the beat when pf_valid && cpu_ready.
REQ-011 Port pf_pc, input, AW+2: address of lane 0 of the beat.
REQ-012 Port pf_insn, input, 32*NLANES: instructions; lane 0 in the LSBs.
REQ-013 Port pf_illegal, input, 1: bus error on this fetch.
REQ-014 Port i_clr_err, input, 1: synchronous clear of o_err_code.
REQ-015 Port o_err, output, 1: OR of o_err_code.
REQ-016 Port o_err_code, output, 5: sticky error bits (see REQ-024).
REQ-017 Port o_beats, output, CW: saturating count of accepted beats.
REQ-018 Port o_stalls, output, CW: saturating count of pf_valid && !cpu_ready cycles.

Function
REQ-019 States SHALL be IDLE (awaiting PC), RUN, ILL (sticky bus error); reset enters IDLE.
REQ-020 IDLE->RUN on cpu_new_pc; any state->IDLE on cpu_clear_cache without cpu_new_pc; RUN->ILL on pf_valid && pf_illegal; ILL->RUN only on cpu_new_pc.
REQ-021 Expected address exp SHALL load cpu_pc on cpu_new_pc; otherwise on accept, exp word field += NLANES modulo 2^AW, exp[1:0] <= 0; cpu_new_pc wins over a simultaneous accept.
REQ-022 A stall snapshot (pf_pc, pf_insn, pf_illegal) SHALL be captured every cycle pf_valid && !cpu_ready.
REQ-023 All checks are combinational on current inputs plus state; a violation sets its bit in o_err_code at the next edge (1-cycle latency).
REQ-024 Bits: [0] HOLD -- previous cycle stalled, no cpu_new_pc then or now, and pf_valid low or any snapshot field changed; [1] ADDR -- pf_valid && !pf_illegal && pf_pc != exp in RUN; [2] EARLY -- pf_valid in IDLE, or pf_valid in the cycle after cpu_clear_cache; [3] ILLDROP -- state ILL, !cpu_new_pc, pf_illegal low; [4] CONTRACT (REQ-030).
REQ-025 Bits SHALL be sticky; i_clr_err clears them, but a violation detected the same cycle sets its bit (set wins).
REQ-026 cpu_new_pc and cpu_clear_cache together SHALL go to RUN with exp <= cpu_pc.
REQ-027 Counters SHALL saturate at 2^CW-1 and never wrap; o_stalls counts in every state.

Reset
REQ-028 Asserting i_reset_n low SHALL immediately force state IDLE, exp 0, snapshot valid 0, o_err_code 0, o_err 0, o_beats 0, o_stalls 0, including mid-stall or mid-burst.
REQ-029 The first edge after deassertion SHALL apply the EARLY check (pf_valid must be low).

Configuration
REQ-030 Macro PFMON_CONTRACT_EN: when defined, add input ports fc_pc (AW+2), fc_insn (32), fc_illegal (1); when pf_valid and fc_pc word lies in the beat's lanes, bit [4] sets if fc_illegal && !pf_illegal, or !fc_illegal && !pf_illegal && lane insn != fc_insn. When undefined, ports absent and bit [4] constant 0.

Structure
REQ-031 Package pfmon_pkg SHALL hold the state enum and error-bit index constants (ERR_HOLD..ERR_CONTRACT).
REQ-032 Sub-module pfmon_satcnt (parameter CW, inc, async reset) SHALL implement both counters.

Verification
REQ-033 Reset release, cpu_new_pc with cpu_pc=0x100, beats at 0x100,0x104 accepted (NLANES=1) -> o_err=0, o_beats=2.
REQ-034 NLANES=2, new PC 0x0FF8 (AW=10), three accepted beats at 0x0FF8, 0x0000, 0x0008 -> no ADDR error (wrap accepted).
REQ-035 pf_valid with insn 0xDEADBEEF stalled 3 cycles, insn changes to 0x0 in cycle 3 -> o_err_code=5'b00001 one cycle later, o_stalls=3.
REQ-036 cpu_clear_cache then pf_valid next cycle -> bit [2] set; i_clr_err same cycle as new violation -> bit remains set.
REQ-037 pf_illegal beat, then pf_illegal dropped without cpu_new_pc -> bit [3]; with cpu_new_pc instead -> no error.
REQ-038 PFMON_CONTRACT_EN, fc_pc=0x200, fc_insn=0x12345678, beat at 0x200 carries 0x12345679 -> bit [4] set; macro undefined -> bit [4] stays 0.
